// File: rtl/spi_slave_16.sv
// 16-bit SPI responder clocked by sclk: captures sdi into rx_data and shifts a preloaded word out on sdo.
// Optional frame-length checking (frame_err port) is enabled by defining SPI_SLAVE_FRAME_CHECK_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | cs high: rearm bit counter, accept tx_load
// ST_SHIFT | cs low, fewer than 16 bits taken: shift both directions
// ST_FULL  | cs low, 16 bits taken (or frame began before reset release): discard
module spi_slave_16 (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        sdi,
  output logic        sdo,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic        tx_busy,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        rx_overrun
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  ,
  output logic        frame_err
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [15:0] tx_shift;
  // The bit shifted out of the top would never be read, so only 15 bits are held.
  logic [14:0] rx_shift;
  logic [4:0]  bit_cnt;
  logic        armed;
  logic [1:0]  state;
  logic        frame_done;

  // armed is cleared by reset and set by the first cs-high edge, so a frame
  // already in progress at reset release is swallowed as if it were full.
  always_comb begin
    state = ST_IDLE;
    if (!cs) begin
      if (armed && (bit_cnt != 5'd16)) state = ST_SHIFT;
      else                             state = ST_FULL;
    end
  end

  assign frame_done = (state == ST_SHIFT) && (bit_cnt == 5'd15);
  assign sdo        = ~cs & tx_shift[15];
  assign tx_busy    = ~cs;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          armed   <= 1'b1;
          if (tx_load) tx_shift <= tx_data;
        end
        ST_SHIFT: begin
          rx_shift <= {rx_shift[13:0], sdi};
          tx_shift <= {tx_shift[14:0], 1'b0};
          bit_cnt  <= bit_cnt + 5'd1;
        end
        default: bit_cnt <= 5'd16;
      endcase
    end
  end

  // Completion takes priority over an acknowledge on the same edge.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (frame_done) begin
      rx_data    <= {rx_shift, sdi};
      rx_valid   <= 1'b1;
      rx_overrun <= ~rx_ack & (rx_overrun | rx_valid);
    end else if (rx_ack) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_FRAME_CHECK_EN
  logic short_frame;
  logic long_frame;

  assign short_frame = (state == ST_IDLE) && (bit_cnt != 5'd0) && (bit_cnt != 5'd16);
  assign long_frame  = (state == ST_FULL) && armed;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)                        frame_err <= 1'b0;
    else if (short_frame || long_frame) frame_err <= 1'b1;
    else if (rx_ack)                    frame_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_slave_16.sv
// Bench for spi_slave_16: word-level model checked every cycle, plus directed literal checks.
// Covers frame_err as well when SPI_SLAVE_FRAME_CHECK_EN is defined.
module tb_spi_slave_16;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b1;
  logic        sdi = 1'b0;
  logic        tx_load = 1'b0;
  logic        rx_ack = 1'b0;
  logic [15:0] tx_data = '0;
  logic        sdo;
  logic        tx_busy;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_overrun;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  logic        frame_err;
`endif

  int n_checks = 0;
  int n_err = 0;

  spi_slave_16 dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .cs(cs),
    .sdi(sdi),
    .sdo(sdo),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_busy(tx_busy),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .rx_overrun(rx_overrun)
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: edges counted per frame, transmit word kept unshifted.
  int          m_edges;
  bit          m_sync;
  logic [15:0] m_word, m_acc, m_rx;
  bit          m_valid, m_over, m_ferr;

  always @(posedge sclk or negedge rst_n) begin
    bit done, err_ev;
    if (!rst_n) begin
      m_edges = 0; m_sync = 0; m_word = '0; m_acc = '0;
      m_rx = '0; m_valid = 0; m_over = 0; m_ferr = 0;
    end else begin
      done = 0;
      err_ev = 0;
      if (cs) begin
        if (m_sync && m_edges > 0 && m_edges < 16) err_ev = 1;
        m_word = (m_edges >= 16) ? 16'h0000 : (m_word << m_edges);
        if (tx_load) m_word = tx_data;
        m_edges = 0;
        m_sync = 1;
        m_acc = '0;
      end else if (m_sync) begin
        if (m_edges < 16) begin
          m_acc = m_acc * 2 + {15'd0, sdi};
          m_edges++;
          done = (m_edges == 16);
        end else begin
          err_ev = 1;
        end
      end
      if (done) begin
        m_over = rx_ack ? 1'b0 : (m_over | m_valid);
        m_valid = 1;
        m_rx = m_acc;
      end else if (rx_ack) begin
        m_valid = 0;
        m_over = 0;
      end
      if (err_ev) m_ferr = 1;
      else if (rx_ack) m_ferr = 0;
    end
  end

  initial begin
    logic e_sdo;
    @(posedge sclk);
    forever begin
      #3;
      e_sdo = (!cs && m_sync && m_edges < 16) ? m_word[15-m_edges] : 1'b0;
      chk("cyc_rx_data", rx_data, m_rx);
      chk("cyc_rx_valid", {15'd0, rx_valid}, {15'd0, m_valid});
      chk("cyc_rx_overrun", {15'd0, rx_overrun}, {15'd0, m_over});
      chk("cyc_sdo", {15'd0, sdo}, {15'd0, e_sdo});
      chk("cyc_tx_busy", {15'd0, tx_busy}, {15'd0, ~cs});
`ifdef SPI_SLAVE_FRAME_CHECK_EN
      chk("cyc_frame_err", {15'd0, frame_err}, {15'd0, m_ferr});
`endif
      @(posedge sclk);
    end
  end

  task automatic run_frame(input logic [15:0] w, input int n, input int ack_idx,
                           input int load_idx, input logic [15:0] load_val,
                           input int rst_idx, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      if (i == rst_idx) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      cs = 1'b0;
      sdi = (i < 16) ? w[15-i] : 1'b1;
      rx_ack = (i == ack_idx);
      tx_load = (i == load_idx);
      if (i == load_idx) tx_data = load_val;
      #1;
      if (i < 16) cap[15-i] = sdo;
    end
    @(negedge sclk);
    cs = 1'b1;
    sdi = 1'b0;
    rx_ack = 1'b0;
    tx_load = 1'b0;
  endtask

  task automatic idle_load(input logic [15:0] val);
    @(negedge sclk);
    tx_load = 1'b1;
    tx_data = val;
    @(negedge sclk);
    tx_load = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge sclk);
    rx_ack = 1'b1;
    @(negedge sclk);
    rx_ack = 1'b0;
  endtask

  task automatic at_e17();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    logic [15:0] cap;
    repeat (3) @(negedge sclk);
    chk("rst_rx_data", rx_data, 16'h0000);
    chk("rst_rx_valid", {15'd0, rx_valid}, 16'h0000);
    chk("rst_rx_overrun", {15'd0, rx_overrun}, 16'h0000);
    chk("rst_sdo", {15'd0, sdo}, 16'h0000);
    chk("rst_tx_busy", {15'd0, tx_busy}, 16'h0000);
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    chk("rst_frame_err", {15'd0, frame_err}, 16'h0000);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    idle_load(16'hA5C3);
    run_frame(16'h1234, 16, -1, -1, 16'h0, -1, cap);
    chk("basic_sdo_seq", cap, 16'hA5C3);
    at_e17();
    chk("basic_rx_data", rx_data, 16'h1234);
    chk("basic_rx_valid", {15'd0, rx_valid}, 16'h0001);

    ack_pulse();
    run_frame(16'h1111, 16, -1, -1, 16'h0, -1, cap);
    chk("consumed_sdo_seq", cap, 16'h0000);
    run_frame(16'h2222, 16, -1, -1, 16'h0, -1, cap);
    at_e17();
    chk("ovr_rx_data", rx_data, 16'h2222);
    chk("ovr_flag", {15'd0, rx_overrun}, 16'h0001);
    ack_pulse();
    at_e17();
    chk("ack_rx_valid", {15'd0, rx_valid}, 16'h0000);
    chk("ack_overrun", {15'd0, rx_overrun}, 16'h0000);

    run_frame(16'h3333, 16, -1, -1, 16'h0, -1, cap);
    run_frame(16'h4444, 16, 15, -1, 16'h0, -1, cap);
    at_e17();
    chk("ackcmp_rx_data", rx_data, 16'h4444);
    chk("ackcmp_rx_valid", {15'd0, rx_valid}, 16'h0001);
    chk("ackcmp_overrun", {15'd0, rx_overrun}, 16'h0000);

    run_frame(16'hABCD, 8, -1, -1, 16'h0, -1, cap);
    at_e17();
    chk("short_rx_data", rx_data, 16'h4444);
    chk("short_rx_valid", {15'd0, rx_valid}, 16'h0001);
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    chk("short_frame_err", {15'd0, frame_err}, 16'h0001);
`endif
    ack_pulse();

    run_frame(16'h5A5A, 18, -1, -1, 16'h0, -1, cap);
    at_e17();
    chk("long_rx_data", rx_data, 16'h5A5A);
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    chk("long_frame_err", {15'd0, frame_err}, 16'h0001);
`endif
    ack_pulse();

    idle_load(16'h0F0F);
    run_frame(16'h1357, 16, -1, 4, 16'hFFFF, -1, cap);
    chk("busyload_sdo_seq", cap, 16'h0F0F);
    run_frame(16'h2468, 16, -1, -1, 16'h0, -1, cap);
    chk("busyload_next_sdo", cap, 16'h0000);
    at_e17();
    chk("busyload_rx_data", rx_data, 16'h2468);
    ack_pulse();

    idle_load(16'hC0DE);
    run_frame(16'h9999, 16, -1, -1, 16'h0, 8, cap);
    at_e17();
    chk("midrst_rx_valid", {15'd0, rx_valid}, 16'h0000);
    chk("midrst_rx_data", rx_data, 16'h0000);
    run_frame(16'h7E81, 16, -1, -1, 16'h0, -1, cap);
    chk("postrst_sdo_seq", cap, 16'h0000);
    at_e17();
    chk("postrst_rx_data", rx_data, 16'h7E81);
    chk("postrst_rx_valid", {15'd0, rx_valid}, 16'h0001);

    repeat (3) @(negedge sclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
